// File: rtl/cmp_sort_ctrl_pkg.sv
// Shared types and width helpers for the cmp_sort_ctrl sorter.
package cmp_sort_pkg;

    localparam int DEF_N = 4;
    localparam int DEF_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int idx_w(input int n);
        return $clog2(n);
    endfunction

    // Wide enough to hold the worst-case swap total n(n-1)/2.
    function automatic int cnt_w(input int n);
        return $clog2(n * (n - 1) / 2 + 1);
    endfunction

endpackage

// File: rtl/cmp_sort_ctrl_if.sv
// Host-side bus of cmp_sort_ctrl: load port, start/status and read-back port.
interface cmp_sort_ctrl_if
    import cmp_sort_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W
);
    logic                  load;
    logic [idx_w(N)-1:0]   load_idx;
    logic [W-1:0]          load_data;
    logic                  start;
    logic                  busy;
    logic                  done;
    logic [idx_w(N)-1:0]   rd_idx;
    logic [W-1:0]          rd_data;
    logic [cnt_w(N)-1:0]   swap_count;

    modport master (
        output load, load_idx, load_data, start, rd_idx,
        input  busy, done, rd_data, swap_count
    );

    modport slave (
        input  load, load_idx, load_data, start, rd_idx,
        output busy, done, rd_data, swap_count
    );
endinterface

// File: rtl/cmp_sort_ctrl_gt.sv
// Unsigned strict greater-than comparator; the sorter's only ordering decision.
module greater_than #(
    parameter int W = 2
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         F
);
    assign F = (A > B);
endmodule

// File: rtl/cmp_sort_ctrl.sv
// In-place ascending bubble sort of N W-bit entries, one compare per cycle.
// Optional build macro CMP_SORT_EARLY_EXIT_EN ends the sort after a swap-free pass.
module cmp_sort_ctrl
    import cmp_sort_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W
) (
    input  logic           clk,
    input  logic           rst_n,
    cmp_sort_ctrl_if.slave bus
);
    localparam int IW = idx_w(N);
    localparam int CW = cnt_w(N);

    state_e          state_q, state_d;
    logic [W-1:0]    mem_q [N];
    logic [W-1:0]    mem_d [N];
    logic [IW-1:0]   j_q, j_d;
    logic [IW-1:0]   pass_q, pass_d;
    logic [CW-1:0]   cnt_q, cnt_d;
`ifdef CMP_SORT_EARLY_EXIT_EN
    logic            swapped_q, swapped_d;
`endif

    logic [IW-1:0]   j_nxt;
    logic            gt;
    logic            last_j;
    logic            last_pass;

    assign j_nxt     = IW'(j_q + 1'b1);
    assign last_j    = (j_q == IW'(N - 2) - pass_q);
    assign last_pass = (pass_q == IW'(N - 2));

    greater_than #(.W(W)) u_gt (
        .A (mem_q[j_q]),
        .B (mem_q[j_nxt]),
        .F (gt)
    );

    always_comb begin
        state_d = state_q;
        mem_d   = mem_q;
        j_d     = j_q;
        pass_d  = pass_q;
        cnt_d   = cnt_q;
`ifdef CMP_SORT_EARLY_EXIT_EN
        swapped_d = swapped_q;
`endif
        case (state_q)
            IDLE: begin
                // start has priority: a coincident load is dropped.
                if (bus.start) begin
                    state_d = RUN;
                    j_d     = '0;
                    pass_d  = '0;
                    cnt_d   = '0;
`ifdef CMP_SORT_EARLY_EXIT_EN
                    swapped_d = 1'b0;
`endif
                end else if (bus.load) begin
                    mem_d[bus.load_idx] = bus.load_data;
                end
            end
            RUN: begin
                if (gt) begin
                    mem_d[j_q]   = mem_q[j_nxt];
                    mem_d[j_nxt] = mem_q[j_q];
                    if (cnt_q != {CW{1'b1}}) cnt_d = CW'(cnt_q + 1'b1);
                end
                if (last_j) begin
                    j_d    = '0;
                    pass_d = IW'(pass_q + 1'b1);
                    if (last_pass) state_d = DONE;
`ifdef CMP_SORT_EARLY_EXIT_EN
                    if (!(swapped_q || gt)) state_d = DONE;
                    swapped_d = 1'b0;
`endif
                end else begin
                    j_d = j_nxt;
`ifdef CMP_SORT_EARLY_EXIT_EN
                    swapped_d = swapped_q || gt;
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the register file is reset too, because a reset must discard any
    // partially sorted contents, not just stop the sequencer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            j_q     <= '0;
            pass_q  <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < N; i++) mem_q[i] <= '0;
`ifdef CMP_SORT_EARLY_EXIT_EN
            swapped_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            pass_q  <= pass_d;
            cnt_q   <= cnt_d;
            mem_q   <= mem_d;
`ifdef CMP_SORT_EARLY_EXIT_EN
            swapped_q <= swapped_d;
`endif
        end
    end

    assign bus.busy       = (state_q == RUN);
    assign bus.done       = (state_q == DONE);
    assign bus.rd_data    = mem_q[bus.rd_idx];
    assign bus.swap_count = cnt_q;
endmodule

// File: doc/cmp_sort_ctrl.md
Name: cmp_sort_ctrl

Overview:
- Sequencer that owns one W-bit greater_than comparator and uses it to bubble-sort a small register file of N entries in place, ascending.
- Host loads entries, pulses start, waits for done, then reads results back.
- Sits between a host or testbench and the comparator datapath. It is the first stateful user of the comparator.

Parameters:
- N, 4, number of entries; legal range 2..16.
- W, 2, entry width in bits; matches the comparator operand width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- load  in  1  write strobe; writes load_data to mem[load_idx]
- load_idx  in  $clog2(N)  write address
- load_data  in  W  write data
- start  in  1  begin sort (single-cycle pulse)
- busy  out  1  high while sorting
- done  out  1  one-cycle completion pulse
- rd_idx  in  $clog2(N)  read address
- rd_data  out  W  combinational mem[rd_idx]
- swap_count  out  CW  number of swaps in the last sort; CW = $clog2(N*(N-1)/2+1)

Behaviour:
- Reset (async, rst_n=0):
  - all mem entries = 0, state = IDLE, busy = 0, done = 0, swap_count = 0
  - pass and index counters = 0
  - takes effect immediately, including mid-sort; any partial result is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - load=1 writes mem at the clock edge.
  - start=1 moves to RUN and clears pass, j and swap_count.
  - If start and load are both high, start wins and the load is dropped.
- RUN, one compare per cycle:
  - Comparator is driven with A=mem[j], B=mem[j+1]; F = A>B, unsigned and strict.
  - If F=1, swap the two entries at the edge and increment swap_count.
  - j runs 0..N-2-pass. After the last j, pass increments and j returns to 0.
  - After pass N-2 completes, go to DONE.
  - Total RUN cycles C = N(N-1)/2, which is 6 for N=4.
- DONE: done=1 for exactly one cycle, then return to IDLE. busy=0 in DONE.
- busy = (state==RUN). It rises on the edge where start is sampled and stays high for exactly C cycles.
- load and start are ignored while in RUN or DONE.
- Equal entries are never swapped, so the sort is stable and idempotent.
- rd_data is live at all times. During RUN it shows intermediate contents; it is valid as the sorted result from the DONE cycle onward.
- swap_count saturates at its max. This is unreachable by construction and kept as a guard.

Optional Feature:
- Macro CMP_SORT_EARLY_EXIT_EN.
- When defined:
  - A per-pass swapped flag is tracked.
  - If a full pass completes with no swap, go directly to DONE.
  - Minimum RUN length is N-1 cycles (an already-sorted input).
- When undefined: RUN always lasts exactly C cycles regardless of data.
- Result contents and swap_count are identical in both builds.

Decomposition:
- Package cmp_sort_pkg holds:
  - state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - a helper for the CW/index width calculation
  - default N and W constants
- One sub-module instance: greater_than, W-bit operands A, B, output F, purely combinational.
- The controller contains no other magnitude compare; every ordering decision goes through F.

Test Plan:
- Sorts a mixed input: load [3,1,2,0], start.
  - busy high 6 cycles, done pulse, mem = [0,1,2,3], swap_count = 5.
- Reverse order: load [3,2,1,0], start.
  - mem = [0,1,2,3], swap_count = 6, 6 busy cycles.
- Sorted and equal inputs: load [0,1,2,3], then [2,2,2,2], start each.
  - Contents unchanged, swap_count = 0.
  - busy lasts 6 cycles without the macro, 3 with CMP_SORT_EARLY_EXIT_EN.
- Ignored inputs while busy:
  - start mid-RUN has no effect; done still fires exactly once.
  - load [x]=3 during RUN does not alter mem.
  - start+load in the same IDLE cycle drops the load.
- Reset mid-sort: assert rst_n=0 at RUN cycle 3, asynchronously, not aligned to clk.
  - Immediately busy=0, done=0, swap_count=0, all mem=0.
  - After release, a new load/start of [1,0,0,0] gives [0,0,0,1] with swap_count=3.
